// File: rtl/sram_pkg.sv
// Shared constants and helpers for the banked dual-port SRAM model.
package sram_pkg;

  localparam int unsigned DEF_WIDTH     = 64;
  localparam int unsigned DEF_DEPTH     = 2048;
  localparam int unsigned DEF_NUM_BANKS = 4;

  // Round-robin pointer encoding
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Low address bits pick the bank (num_banks is a power of 2)
  function automatic int unsigned bank_idx(input logic [31:0] addr,
                                           input int unsigned num_banks);
    return addr & (num_banks - 32'd1);
  endfunction

endpackage

// File: rtl/sram_bank.sv
// One single-port bank: synchronous write, read registered into q.
// SRAM_BYTE_MASK_EN adds an active-low per-byte write mask.
module sram_bank #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 512,
  parameter int unsigned ROW_W = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             we,
  input  logic [ROW_W-1:0] row,
  input  logic [WIDTH-1:0] d,
`ifdef SRAM_BYTE_MASK_EN
  input  logic [WIDTH/8-1:0] bwen,
`endif
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array is never reset; requests during reset must not touch it
  always_ff @(posedge clk) begin
    if (reset_n && en && we) begin
`ifdef SRAM_BYTE_MASK_EN
      for (int unsigned i = 0; i < WIDTH/8; i++) begin
        if (!bwen[i]) mem[row][i*8 +: 8] <= d[i*8 +: 8];
      end
`else
      mem[row] <= d;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (en && !we) begin
      q <= mem[row];
    end
  end

endmodule

// File: rtl/sram_banked_dp.sv
// Two-port bank-interleaved SRAM with round-robin same-bank arbitration.
// Define SRAM_BYTE_MASK_EN to add active-low byte write enables bwen0/bwen1.
module sram_banked_dp
  import sram_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned NUM_BANKS = DEF_NUM_BANKS,
  parameter int unsigned ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cen0,
  input  logic              cen1,
  input  logic              wen0,
  input  logic              wen1,
  input  logic [ADDR_W-1:0] a0,
  input  logic [ADDR_W-1:0] a1,
  input  logic [WIDTH-1:0]  d0,
  input  logic [WIDTH-1:0]  d1,
`ifdef SRAM_BYTE_MASK_EN
  input  logic [WIDTH/8-1:0] bwen0,
  input  logic [WIDTH/8-1:0] bwen1,
`endif
  output logic              rdy0,
  output logic              rdy1,
  output logic [WIDTH-1:0]  q0,
  output logic [WIDTH-1:0]  q1,
  output logic              qv0,
  output logic              qv1
);

  localparam int unsigned BANK_BITS  = $clog2(NUM_BANKS);
  localparam int unsigned BANK_W     = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int unsigned ROW_W      = (ADDR_W > BANK_BITS) ? ADDR_W - BANK_BITS : 1;
  localparam int unsigned BANK_DEPTH = DEPTH / NUM_BANKS;

  logic [BANK_W-1:0] b0, b1, bsel0, bsel1;
  logic [ROW_W-1:0]  row0, row1;
  logic              req0, req1, conflict, acc0, acc1, rr;
  logic [WIDTH-1:0]  qh0, qh1;
  logic [WIDTH-1:0]  bank_q [NUM_BANKS];

  assign b0   = BANK_W'(bank_idx(32'(a0), NUM_BANKS));
  assign b1   = BANK_W'(bank_idx(32'(a1), NUM_BANKS));
  assign row0 = ROW_W'(a0 >> BANK_BITS);
  assign row1 = ROW_W'(a1 >> BANK_BITS);

  // Arbitration depends only on cen/a/rr
  assign req0     = ~cen0;
  assign req1     = ~cen1;
  assign conflict = req0 && req1 && (b0 == b1);
  assign rdy0     = ~conflict || (rr == PORT0);
  assign rdy1     = ~conflict || (rr == PORT1);
  assign acc0     = req0 && rdy0;
  assign acc1     = req1 && rdy1;

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    logic hit0, hit1;
    assign hit0 = acc0 && (b0 == BANK_W'(k));
    assign hit1 = acc1 && (b1 == BANK_W'(k));

    sram_bank #(
      .WIDTH (WIDTH),
      .DEPTH (BANK_DEPTH),
      .ROW_W (ROW_W)
    ) u_bank (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (hit0 || hit1),
      .we      (hit0 ? ~wen0 : ~wen1),
      .row     (hit0 ? row0 : row1),
      .d       (hit0 ? d0 : d1),
`ifdef SRAM_BYTE_MASK_EN
      .bwen    (hit0 ? bwen0 : bwen1),
`endif
      .q       (bank_q[k])
    );
  end

  // Pointer moves to the loser after a conflict; qh keeps q stable between reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr    <= PORT0;
      qv0   <= 1'b0;
      qv1   <= 1'b0;
      bsel0 <= '0;
      bsel1 <= '0;
      qh0   <= '0;
      qh1   <= '0;
    end else begin
      if (conflict) rr <= ~rr;
      qv0 <= acc0 && wen0;
      qv1 <= acc1 && wen1;
      if (acc0 && wen0) bsel0 <= b0;
      if (acc1 && wen1) bsel1 <= b1;
      if (qv0) qh0 <= bank_q[bsel0];
      if (qv1) qh1 <= bank_q[bsel1];
    end
  end

  assign q0 = qv0 ? bank_q[bsel0] : qh0;
  assign q1 = qv1 ? bank_q[bsel1] : qh1;

endmodule

// File: tb/tb_sram_banked_dp.sv
// Scoreboard bench for sram_banked_dp (default 64x2048, 4 banks).
module tb_sram_banked_dp;

`ifdef SRAM_BYTE_MASK_EN
  localparam bit MASKED = 1'b1;
`else
  localparam bit MASKED = 1'b0;
`endif

  logic        clk, reset_n;
  logic        cen0, cen1, wen0, wen1;
  logic [10:0] a0, a1;
  logic [63:0] d0, d1;
  logic [7:0]  bw0, bw1;
  logic        rdy0, rdy1, qv0, qv1;
  logic [63:0] q0, q1;

  sram_banked_dp dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cen0    (cen0),
    .cen1    (cen1),
    .wen0    (wen0),
    .wen1    (wen1),
    .a0      (a0),
    .a1      (a1),
    .d0      (d0),
    .d1      (d1),
`ifdef SRAM_BYTE_MASK_EN
    .bwen0   (bw0),
    .bwen1   (bw1),
`endif
    .rdy0    (rdy0),
    .rdy1    (rdy1),
    .q0      (q0),
    .q1      (q1),
    .qv0     (qv0),
    .qv1     (qv1)
  );

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t        expq [2][$];
  logic [63:0] model [int];
  logic [63:0] last [2];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  // Monitor: pops expected reads when qv is seen, checks q holds otherwise
  always @(negedge clk) begin
    logic        qv_a [2];
    logic [63:0] q_a [2];
    exp_t        e;
    qv_a[0] = qv0; qv_a[1] = qv1;
    q_a[0]  = q0;  q_a[1]  = q1;
    if (!reset_n) begin
      last[0] = '0;
      last[1] = '0;
    end
    for (int p = 0; p < 2; p++) begin
      if (qv_a[p]) begin
        checks++;
        if (expq[p].size() == 0) begin
          errors++;
          $display("FAIL qv%0d_unexpected cyc=%0d q=%h", p, cyc, q_a[p]);
        end else begin
          e = expq[p].pop_front();
          if (q_a[p] !== e.data || e.due != cyc) begin
            errors++;
            $display("FAIL rd_data%0d got q=%h at cyc %0d, want %h at cyc %0d",
                     p, q_a[p], cyc, e.data, e.due);
          end
          last[p] = e.data;
        end
      end else begin
        if (expq[p].size() > 0 && expq[p][0].due <= cyc) begin
          checks++;
          errors++;
          $display("FAIL qv%0d_missing cyc=%0d want data %h", p, cyc, expq[p][0].data);
          void'(expq[p].pop_front());
        end
        checks++;
        if (q_a[p] !== last[p]) begin
          errors++;
          $display("FAIL q%0d_hold cyc=%0d got %h want %h", p, cyc, q_a[p], last[p]);
        end
      end
    end
  end

  function automatic void mwrite(input int addr, input logic [63:0] d, input logic [7:0] bw);
    logic [63:0] v;
    v = model.exists(addr) ? model[addr] : 'x;
    for (int i = 0; i < 8; i++) begin
      if (!bw[i]) v[i*8 +: 8] = d[i*8 +: 8];
    end
    model[addr] = v;
  endfunction

  task automatic setp(input int p, input logic c, input logic w, input int a,
                      input logic [63:0] d);
    if (p == 0) begin
      cen0 = c; wen0 = w; a0 = 11'(a); d0 = d;
    end else begin
      cen1 = c; wen1 = w; a1 = 11'(a); d1 = d;
    end
  endtask

  // Check rdy against expectation, record accepted ops, then cross the edge
  task automatic do_cycle(input logic er0, input logic er1, input bit push);
    @(negedge clk);
    checks += 2;
    if (rdy0 !== er0) begin
      errors++;
      $display("FAIL rdy0 cyc=%0d got %b want %b", cyc, rdy0, er0);
    end
    if (rdy1 !== er1) begin
      errors++;
      $display("FAIL rdy1 cyc=%0d got %b want %b", cyc, rdy1, er1);
    end
    if (!cen0 && er0) begin
      if (!wen0) mwrite(int'(a0), d0, MASKED ? bw0 : 8'h00);
      else if (push) expq[0].push_back('{model[int'(a0)], cyc + 1});
    end
    if (!cen1 && er1) begin
      if (!wen1) mwrite(int'(a1), d1, MASKED ? bw1 : 8'h00);
      else if (push) expq[1].push_back('{model[int'(a1)], cyc + 1});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    bw0 = 8'h00; bw1 = 8'h00;
    setp(0, 1'b1, 1'b1, 0, 64'h0);
    setp(1, 1'b1, 1'b1, 0, 64'h0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // First conflict after reset grants port 0, then port 1
    setp(0, 1'b0, 1'b0, 8,  64'h1111_2222_3333_4444);
    setp(1, 1'b0, 1'b0, 12, 64'h5555_6666_7777_8888);
    do_cycle(1'b1, 1'b0, 1'b1);
    setp(0, 1'b0, 1'b0, 16, 64'h9999_AAAA_BBBB_CCCC);
    do_cycle(1'b0, 1'b1, 1'b1);
    setp(1, 1'b1, 1'b1, 0, 64'h0);
    do_cycle(1'b1, 1'b1, 1'b1);

    // Write then read back on port 0
    setp(0, 1'b0, 1'b0, 5, 64'hDEAD_BEEF_0000_0001);
    do_cycle(1'b1, 1'b1, 1'b1);
    setp(0, 1'b0, 1'b1, 5, 64'h0);
    do_cycle(1'b1, 1'b1, 1'b1);

    // Different banks: both ports served together
    setp(0, 1'b0, 1'b0, 4,  64'hA5A5_A5A5_5A5A_5A5A);
    setp(1, 1'b0, 1'b0, 13, 64'h0123_4567_89AB_CDEF);
    do_cycle(1'b1, 1'b1, 1'b1);
    setp(0, 1'b0, 1'b1, 4, 64'h0);
    setp(1, 1'b0, 1'b1, 5, 64'h0);
    do_cycle(1'b1, 1'b1, 1'b1);

    // Persistent same-bank reads alternate strictly
    setp(0, 1'b0, 1'b1, 8,  64'h0);
    setp(1, 1'b0, 1'b1, 12, 64'h0);
    do_cycle(1'b1, 1'b0, 1'b1);
    do_cycle(1'b0, 1'b1, 1'b1);
    do_cycle(1'b1, 1'b0, 1'b1);
    do_cycle(1'b0, 1'b1, 1'b1);

    // Partial overwrite (full overwrite without the byte mask)
    setp(1, 1'b1, 1'b1, 0, 64'h0);
    setp(0, 1'b0, 1'b0, 3, 64'hFFFF_FFFF_FFFF_FFFF);
    do_cycle(1'b1, 1'b1, 1'b1);
    bw0 = 8'b1111_0000;
    setp(0, 1'b0, 1'b0, 3, 64'h0);
    do_cycle(1'b1, 1'b1, 1'b1);
    bw0 = 8'hFF;
    setp(0, 1'b0, 1'b1, 3, 64'h0);
    setp(1, 1'b0, 1'b1, 13, 64'h0);
    do_cycle(1'b1, 1'b1, 1'b1);
    setp(0, 1'b1, 1'b1, 0, 64'h0);
    setp(1, 1'b1, 1'b1, 0, 64'h0);
    do_cycle(1'b1, 1'b1, 1'b1);

    // Reset right after an accepted read: pulse dropped, array intact
    setp(1, 1'b0, 1'b1, 12, 64'h0);
    do_cycle(1'b1, 1'b1, 1'b0);
    reset_n = 1'b0;
    setp(1, 1'b1, 1'b1, 0, 64'h0);
    setp(0, 1'b0, 1'b0, 8, 64'h0BAD_0BAD_0BAD_0BAD);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    setp(0, 1'b0, 1'b1, 8,  64'h0);
    setp(1, 1'b0, 1'b1, 12, 64'h0);
    do_cycle(1'b1, 1'b0, 1'b1);
    do_cycle(1'b0, 1'b1, 1'b1);
    setp(0, 1'b1, 1'b1, 0, 64'h0);
    setp(1, 1'b1, 1'b1, 0, 64'h0);
    do_cycle(1'b1, 1'b1, 1'b1);
    do_cycle(1'b1, 1'b1, 1'b1);

    for (int p = 0; p < 2; p++) begin
      checks++;
      if (expq[p].size() != 0) begin
        errors++;
        $display("FAIL drain%0d pending=%0d want 0", p, expq[p].size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_banked_dp.md
# sram_banked_dp

Two-port, bank-interleaved, parametrised SRAM model for the accelerator's activation/weight buffers. It succeeds the fixed 64x2048 single-port macro model. It keeps the same active-low CEN/WEN request semantics and adds configurable width, depth and bank count. Two independent request ports are served in the same cycle when they hit different banks; same-bank collisions are resolved by round-robin arbitration with a ready back-pressure signal.

## Interface
- WIDTH, 64: data word width in bits.
- DEPTH, 2048: total words; power of 2.
- NUM_BANKS, 4: number of interleaved banks; power of 2, 1..DEPTH.
- ADDR_W, $clog2(DEPTH): address width (derived).
- clk  input  1  clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- cen0, cen1  input  1  per-port chip enable, active-low (request present when 0).
- wen0, wen1  input  1  per-port write enable: 0 = write, 1 = read (valid when cen=0).
- a0, a1  input  ADDR_W  word address.
- d0, d1  input  WIDTH  write data.
- rdy0, rdy1  output  1  request accepted this cycle (combinational).
- q0, q1  output  WIDTH  registered read data.
- qv0, qv1  output  1  read data valid, one-cycle pulse.

## Operation
- Bank index = a[log2(NUM_BANKS)-1:0]. Row within bank = remaining upper bits. Bank depth = DEPTH/NUM_BANKS.
- Conflict = (cen0==0) && (cen1==0) && bank(a0)==bank(a1). Any op mix (R/R, R/W, W/W) counts.
- No conflict: every active request is accepted. rdyP=1 whenever cenP=1.
- On conflict, the port named by the round-robin pointer `rr` wins, and the loser's rdy=0.
  - After a conflict cycle, `rr` flips to the losing port.
  - Non-conflict cycles leave `rr` unchanged.
- The loser must hold cen/wen/a/d stable until rdy=1. The block keeps no request queue.
- Accepted write: the bank row is written at the clock edge.
- Accepted read: the bank row is captured into qP at the clock edge, and qvP=1 for the following cycle. qP holds its value until the next accepted read on that port.
- Write followed by a read of the same address on a later cycle returns the new data. The block has no same-edge read/write hazard, because same-bank requests never both issue.
- Reset:
  - rr=0 (port 0 favoured first), q0=q1=0, qv0=qv1=0.
  - Array contents are not reset and read as X until written.
  - Assertion mid-operation discards any pending qv pulse. A request presented during reset is not accepted and has no effect on the array.

## Timing
- Read latency 1: request accepted at edge N, and qP/qvP are valid in the cycle after edge N.
- Back-to-back accepted reads on one port give continuous qv=1.
- rdy is a combinational function of cen0/cen1/a0/a1/rr only, with no path from d or q.
- Worst-case stall for a persistent same-bank pair: 1 cycle per port (strict alternation).
- Throughput: 2 ops/cycle with no conflict, 1 op/cycle under conflict.

## Configuration
- SRAM_BYTE_MASK_EN defined:
  - Adds ports bwen0, bwen1 (input, WIDTH/8, active-low byte write enable). WIDTH must be a multiple of 8.
  - On an accepted write, only bytes with bwen bit = 0 are updated. bwen is ignored for reads and does not affect arbitration.
- SRAM_BYTE_MASK_EN undefined: the bwen ports are absent and writes always update the full word.

## Structure
- Package sram_pkg holds:
  - default WIDTH/DEPTH/NUM_BANKS constants;
  - port index constants PORT0=0, PORT1=1 (rr encoding);
  - a bank-index helper function.
- Sub-module sram_bank: one bank with a single-port array, synchronous write, and read registered into a data-out register. It takes the optional byte mask and is instantiated NUM_BANKS times via generate.
- The top level holds the conflict detect, round-robin pointer, per-bank port mux, and per-port q/qv return mux. The return mux selects on the bank index registered at acceptance.

## Test plan
- Reset → q0=q1=0, qv0=qv1=0, and the first conflict grants port 0.
- Port0 writes 0xDEAD_BEEF_0000_0001 @ addr 5; next cycle port0 reads addr 5 → qv0=1 one cycle later, q0=0xDEAD_BEEF_0000_0001.
- Port0 reads addr 4 and port1 reads addr 5 in the same cycle (banks 0,1) → rdy0=rdy1=1, and both qv are high in the next cycle with correct data.
- Both ports hold requests to addrs 8 and 12 (bank 0) for 4 cycles → rdy alternates 10,01,10,01 and rr toggles every cycle.
- With SRAM_BYTE_MASK_EN: write 0xFFFF_FFFF_FFFF_FFFF to addr 3, then write 0 with bwen0=8'b1111_0000 → readback 0xFFFF_FFFF_0000_0000.
- Assert reset_n=0 in the cycle after a read is accepted → qv is never seen, q=0, and the array data from prior writes is intact after reset.
